// File: rtl/uart_receiver.sv
// uart_receiver
//   Serial-to-parallel UART receiver: idle-high line, one low start bit,
//   8 data bits LSB first, no parity, at least one high stop bit. Each bit
//   lasts BIT_CLKS clk cycles (even, >= 4). Received bytes are offered to
//   the consumer on a four-phase REQ/ACK handshake.
//
// Ports
//   clk       system clock, rising edge
//   clr       asynchronous active-low reset
//   RCV       serial line (asynchronous to clk, idle high)
//   RCV_ACK   consumer acknowledge for the byte on RCV_DATA
//   RCV_REQ   high while RCV_DATA holds an unacknowledged byte
//   RCV_DATA  last good received byte
//   RCV_ERR   one-cycle pulse on a framing error (stop bit sampled low)
//   RCV_OVR   sticky overrun flag, cleared only by reset
//   state     receive FSM state, for observation
//
// Handshake: RCV_REQ rises together with the RCV_DATA update and RCV_DATA is
// held stable while RCV_REQ=1. RCV_REQ falls on the edge after RCV_ACK is
// sampled high. A new byte is only presented while RCV_REQ=0; the consumer
// must drop RCV_ACK before the next RCV_REQ rises. A byte completing while
// RCV_REQ=1 (including the cycle ACK is sampled) is dropped and flags overrun.
module uart_receiver #(
  parameter int BIT_CLKS = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       RCV,
  input  logic       RCV_ACK,
  output logic       RCV_REQ,
  output logic [7:0] RCV_DATA,
  output logic       RCV_ERR,
  output logic       RCV_OVR,
  output logic [2:0] state
);

  localparam int CW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] HALF = CW'(BIT_CLKS / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BIT_CLKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            sync1, sync2;
  logic            s;
  logic            accept, overrun, ferr;

  assign s     = sync2;
  assign state = state_q;

  // Two-flop synchronizer; reset to the idle (high) line level so that
  // leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= RCV;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    accept  = 1'b0;
    overrun = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      IDLE: begin
        // Half a bit to the middle of the start bit.
        if (!s) begin
          cnt_d   = HALF;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (s) begin
            state_d = IDLE;  // too short to be a start bit
          end else begin
            cnt_d   = FULL;
            idx_d   = 3'd0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {s, shift_q[7:1]};  // LSB arrives first
          cnt_d   = FULL;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (s) begin
            if (RCV_REQ) begin
              overrun = 1'b1;
            end else begin
              accept = 1'b1;
            end
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_IDLE: begin
        // A stuck-low line must not decode as a stream of 0x00 frames.
        if (s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output handshake runs independently of the receive FSM. accept is only
  // raised while RCV_REQ=0, so it never competes with the ACK clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      RCV_REQ  <= 1'b0;
      RCV_DATA <= 8'h00;
      RCV_ERR  <= 1'b0;
      RCV_OVR  <= 1'b0;
    end else begin
      RCV_ERR <= ferr;
      if (overrun) begin
        RCV_OVR <= 1'b1;
      end
      if (accept) begin
        RCV_REQ  <= 1'b1;
        RCV_DATA <= shift_q;
      end else if (RCV_REQ && RCV_ACK) begin
        RCV_REQ <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed bench for uart_receiver at BIT_CLKS=8. The main process drives
//   frames and pushes each byte that must be delivered onto exp_q; a monitor
//   process pops and compares on every RCV_REQ rising edge and also checks
//   that every RCV_ERR pulse is exactly one cycle wide.
module tb_uart_receiver;

  localparam int BC = 8;

  logic       clk;
  logic       clr;
  logic       rcv;
  logic       rcv_ack;
  logic       rcv_req;
  logic [7:0] rcv_data;
  logic       rcv_err;
  logic       rcv_ovr;
  logic [2:0] state;

  uart_receiver #(.BIT_CLKS(BC)) dut (
    .clk      (clk),
    .clr      (clr),
    .RCV      (rcv),
    .RCV_ACK  (rcv_ack),
    .RCV_REQ  (rcv_req),
    .RCV_DATA (rcv_data),
    .RCV_ERR  (rcv_err),
    .RCV_OVR  (rcv_ovr),
    .state    (state)
  );

  // clock / cycle count
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [7:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;
  int rx_cnt     = 0;
  int err_pulses = 0;
  int start_cyc  = 0;
  bit lat_check  = 1'b0;
  bit ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver: start bit, 8 data bits LSB first, stop level for stop_bits bits
  task automatic send_frame(input logic [7:0] b, input int stop_bits, input logic stop_val);
    start_cyc = cyc;
    rcv = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      rcv = b[i];
      tick(BC);
    end
    rcv = stop_val;
    tick(BC * stop_bits);
    rcv = 1'b1;
  endtask

  task automatic wait_req(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (rcv_req !== val && n < budget) begin
      tick(1);
      n++;
    end
    ok = (rcv_req === val);
    if (!ok) check({name, "_timeout"}, 32'(rcv_req), 32'(val));
  endtask

  task automatic do_ack(input string name);
    rcv_ack = 1'b1;
    tick(1);
    check({name, "_req_drop"}, 32'(rcv_req), 32'd0);
    wait_req(1'b0, 10, name);
    rcv_ack = 1'b0;
  endtask

  // monitor: compares delivered bytes against exp_q and ERR pulse widths
  task automatic monitor();
    logic req_prev;
    int   err_len;
    logic [7:0] e;
    req_prev = 1'b0;
    err_len  = 0;
    forever begin
      @(negedge clk);
      if (rcv_req === 1'b1 && req_prev !== 1'b1) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'(rcv_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", 32'(rcv_data), 32'(e));
        end
        if (lat_check) begin
          vectors++;
          if (cyc - start_cyc < 78 || cyc - start_cyc > 80) begin
            miscompares++;
            $display("FAIL latency: got %0d cycles expected 78..80", cyc - start_cyc);
          end
        end
      end
      req_prev = rcv_req;
      if (rcv_err === 1'b1) begin
        err_len++;
      end else if (err_len != 0) begin
        check("err_width", 32'(err_len), 32'd1);
        err_pulses++;
        err_len = 0;
      end
    end
  endtask

  initial begin
    clr     = 1'b0;
    rcv     = 1'b1;
    rcv_ack = 1'b0;
    fork
      monitor();
    join_none

    // reset while the line toggles
    for (int i = 0; i < 20; i++) begin
      rcv = ($urandom_range(0, 1) == 1);
      tick(1);
    end
    check("rst_req",   32'(rcv_req),  32'd0);
    check("rst_data",  32'(rcv_data), 32'h00);
    check("rst_err",   32'(rcv_err),  32'd0);
    check("rst_ovr",   32'(rcv_ovr),  32'd0);
    check("rst_state", 32'(state),    32'd0);
    rcv = 1'b1;
    tick(1);
    clr = 1'b1;
    tick(100);
    check("idle_req", 32'(rcv_req), 32'd0);
    check("idle_rx",  32'(rx_cnt),  32'd0);

    // single byte with latency check
    lat_check = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1, 1'b1);
    tick(2);
    lat_check = 1'b0;
    check("a5_rx", 32'(rx_cnt), 32'd1);
    do_ack("a5");
    check("a5_err", 32'(err_pulses), 32'd0);

    // glitch then a good frame
    rcv = 1'b0;
    tick(2);
    rcv = 1'b1;
    tick(20);
    check("glitch_req",   32'(rcv_req),    32'd0);
    check("glitch_state", 32'(state),      32'd0);
    check("glitch_err",   32'(err_pulses), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1, 1'b1);
    tick(2);
    check("3c_rx", 32'(rx_cnt), 32'd2);
    do_ack("3c");

    // framing error: stop held low for 3 bit times
    send_frame(8'h5A, 3, 1'b0);
    tick(2 * BC);
    check("ferr_pulses", 32'(err_pulses), 32'd1);
    check("ferr_req",    32'(rcv_req),    32'd0);
    check("ferr_rx",     32'(rx_cnt),     32'd2);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1, 1'b1);
    tick(2);
    check("81_rx", 32'(rx_cnt), 32'd3);
    do_ack("81");

    // overrun
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1, 1'b1);
    send_frame(8'h22, 1, 1'b1);
    tick(2);
    check("ovr_data", 32'(rcv_data), 32'h11);
    check("ovr_flag", 32'(rcv_ovr),  32'd1);
    check("ovr_req",  32'(rcv_req),  32'd1);
    do_ack("ovr");
    check("ovr_sticky", 32'(rcv_ovr), 32'd1);

    // back-to-back frames with 1-bit stop gaps, ACK 2 clk after each REQ
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    fork
      begin
        send_frame(8'h00, 1, 1'b1);
        send_frame(8'hFF, 1, 1'b1);
        send_frame(8'h55, 1, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_req(1'b1, 200, "b2b_req");
          tick(2);
          rcv_ack = 1'b1;
          wait_req(1'b0, 10, "b2b_drop");
          rcv_ack = 1'b0;
        end
      end
    join
    tick(2);
    check("b2b_rx",   32'(rx_cnt),     32'd7);
    check("b2b_err",  32'(err_pulses), 32'd1);

    // reset in the middle of a fourth frame
    rcv = 1'b0;
    tick(BC);
    rcv = 1'b1;
    tick(BC);
    rcv = 1'b0;
    tick(BC / 2);
    clr = 1'b0;
    tick(2);
    check("mid_rst_state", 32'(state),    32'd0);
    check("mid_rst_data",  32'(rcv_data), 32'h00);
    check("mid_rst_ovr",   32'(rcv_ovr),  32'd0);
    check("mid_rst_req",   32'(rcv_req),  32'd0);
    rcv = 1'b1;
    tick(1);
    clr = 1'b1;
    tick(100);
    check("post_rst_req", 32'(rcv_req), 32'd0);
    check("post_rst_rx",  32'(rx_cnt),  32'd7);
    check("exp_q_empty",  32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel receiver for the team's UART link; the receive-side counterpart of the byte transmitter.
- Frame format: idle-high line, one low start bit, 8 data bits LSB first, no parity, then at least one high stop bit.
- Each bit lasts BIT_CLKS clk cycles.
- Presents each received byte on a four-phase REQ/ACK handshake to the downstream consumer.

Parameters:
- BIT_CLKS, 8, clk cycles per serial bit; must be even and >= 4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  asynchronous, active-low reset (0 = reset).
- RCV  input  1  serial line, asynchronous to clk, idle high.
- RCV_ACK  input  1  consumer acknowledge for the current byte.
- RCV_REQ  output  1  high while RCV_DATA holds an unacknowledged byte.
- RCV_DATA  output  8  last good received byte.
- RCV_ERR  output  1  one-cycle pulse on a framing error (stop bit sampled low).
- RCV_OVR  output  1  sticky overrun flag; cleared only by reset.

Behaviour:
- Reset (clr=0, async): state IDLE; RCV_REQ=0, RCV_DATA=8'h00, RCV_ERR=0, RCV_OVR=0; bit counter and cycle counter 0; both synchronizer flops set to 1. Reset mid-frame aborts the frame with no output.
- RCV passes through a 2-flop synchronizer reset to 1. All line tests use the synchronized value s.
- Cycle counter cnt, width ceil(log2(BIT_CLKS)).
- IDLE: wait for s=0. On the first cycle with s=0, load cnt=BIT_CLKS/2-1 and go to START.
- START: decrement cnt. At cnt=0, sample s:
  - s=1: glitch; return to IDLE with no output.
  - s=0: load cnt=BIT_CLKS-1, bit index=0, go to DATA.
- DATA: decrement cnt. At cnt=0, shift s into shift[7] and shift right, so the LSB arrives first.
  - If index<7: increment index and reload cnt=BIT_CLKS-1.
  - After index 7: reload cnt and go to STOP.
- Each data bit is sampled BIT_CLKS/2 cycles after its nominal leading edge, i.e. mid-bit.
- STOP: at cnt=0, sample s.
  - s=1 and RCV_REQ=0: RCV_DATA<=shift; RCV_REQ<=1 on the next edge; go to IDLE.
  - s=1 and RCV_REQ=1: the previous byte is unconsumed. Set RCV_OVR=1, drop the new byte, leave RCV_DATA unchanged, go to IDLE.
  - s=0: assert RCV_ERR for exactly one cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until s=1, then go to IDLE. This prevents a stuck-low line from being decoded as repeated 0x00 frames.
- Handshake:
  - RCV_REQ rises together with the RCV_DATA update. RCV_DATA is stable while RCV_REQ=1.
  - RCV_REQ falls on the cycle after RCV_ACK is sampled high.
  - A new byte may be presented only once RCV_REQ=0. RCV_ACK is not required to be low first; the consumer must drop ACK before the next REQ rises.
  - The handshake runs independently of the receive FSM. Reception continues while RCV_REQ is high.
- Latency: RCV_REQ rises 2 (sync) + BIT_CLKS/2 + 9*BIT_CLKS + 1 clk after the RCV falling edge, give or take 1 cycle of sampling phase. For BIT_CLKS=8 that is 79 cycles.
- Simultaneous events: if the STOP-sample accept and RCV_ACK fall on the same cycle, ACK is evaluated first. REQ is already 1 on that cycle, so the frame counts as overrun. The frame is not lost silently.
- Back-to-back frames: a start edge is accepted on the first IDLE cycle after STOP, so a 1-bit stop gap is sufficient.

Test Plan:
- Reset: clr=0 while RCV toggles → all outputs 0, RCV_DATA=00; release clr, RCV held 1 for 100 clk → RCV_REQ stays 0.
- Single byte 0xA5 at BIT_CLKS=8 with stop bit high → RCV_REQ=1 with RCV_DATA=A5 within 79±1 clk of the start edge; assert RCV_ACK → REQ low next cycle; RCV_ERR=0 throughout.
- Glitch: RCV low for 2 clk then high → no REQ, no ERR, FSM back in IDLE; a following 0x3C frame is received correctly.
- Framing error: send 0x5A with the stop bit held low for 3 bit times → RCV_ERR high exactly 1 cycle, no REQ; line returns high, then 0x81 → REQ with 81.
- Overrun: send 0x11 and leave ACK low, then send 0x22 → RCV_DATA stays 11, RCV_OVR=1; ACK → REQ drops, OVR stays 1.
- Back-to-back 0x00, 0xFF, 0x55 with 1-bit stop gaps, ACK issued 2 clk after each REQ → three REQs in order with the correct data; a mid-frame clr pulse during a fourth frame → no REQ, outputs reset.
